mod5_frame_tx: RTL and testbench

MOD5_FRAME_TX -- requirements
Module: mod5_frame_tx

---
 rtl/mod5_frame_tx_if.sv | 57 +++++
 rtl/mod5_frame_tx.sv | 194 +++++++++++++++++++
 tb/tb_mod5_frame_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod5_frame_tx_if.sv
// -----------------------------------------------------------------------------
// mod5_frame_tx_if
//   Bundles the payload handshake and the serial frame outputs of
//   mod5_frame_tx.
//
//   Handshake: a payload transfer happens on a rising clk edge where
//   din_valid=1 and din_ready=1. din is captured at that edge. din_valid
//   seen while din_ready=0 is ignored, and nothing is queued.
//
//   Signals
//     din         [DATA_W-1:0]  payload word (producer -> transmitter)
//     din_valid                 payload offered (producer -> transmitter)
//     din_ready                 transmitter idle, can accept a payload
//     sout                      serial frame bit, MSB first, 0 when not valid
//     sout_valid                sout carries a frame bit this cycle
//     frame_start               pulse on the first frame bit
//     frame_end                 pulse on the last frame bit
//     chk         [2:0]         check value of the current or last frame
//
//   Modports
//     master : the producer / frame consumer side (drives din, din_valid)
//     slave  : the transmitter side (mod5_frame_tx)
// -----------------------------------------------------------------------------
interface mod5_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              sout;
    logic              sout_valid;
    logic              frame_start;
    logic              frame_end;
    logic [2:0]        chk;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_end,
        input  chk
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_end,
        output chk
    );
endinterface

// File: rtl/mod5_frame_tx.sv
// -----------------------------------------------------------------------------
// mod5_frame_tx
//   Serial frame transmitter. Each accepted payload word is sent MSB first,
//   followed by three check bits c[2:0] chosen so the whole
//   (DATA_W+3)-bit frame value is an exact multiple of 5.
//
//   The residue r = payload mod 5 is accumulated one bit at a time while the
//   payload is shifted out (r <- (2r + b) mod 5). Appending three zero bits
//   multiplies by 8 (= 3 mod 5), so the check value must cancel 3r mod 5,
//   which gives c = 2r mod 5 = {0,2,4,1,3}[r].
//
//   Timing: the handshake edge already registers the first payload bit, so
//   the frame starts in the cycle directly after the handshake. A frame
//   occupies DATA_W+3 consecutive cycles, then one IDLE cycle follows in
//   which din_ready=1, so back-to-back frames are separated by one gap cycle.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset (aborts any frame)
//     bus          mod5_frame_tx_if.slave (handshake + serial outputs)
//     dbg_state_o  current FSM state (0=IDLE, 1=DATA, 2=CHECK)
//
//   All outputs come straight from flops; nothing depends combinationally
//   on din or din_valid.
// -----------------------------------------------------------------------------
module mod5_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mod5_frame_tx_if.slave        bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Index of the last payload bit; the counter holds the index of the bit
    // currently on sout while in DATA, and of the check bit while in CHECK.
    localparam logic [4:0] LAST_DATA = 5'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;   // payload bits not yet on sout
    logic [2:0]        res_q,   res_d;     // residue of the bits sent so far
    logic [4:0]        cnt_q,   cnt_d;
    logic              sout_q,  sout_d;
    logic              vld_q,   vld_d;
    logic              fs_q,    fs_d;
    logic              fe_q,    fe_d;
    logic [2:0]        chk_q,   chk_d;
    logic [2:0]        chk_new;

    // (2r + b) mod 5 for r in 0..4: {r,b} is 2r+b, at most 9, so one
    // conditional subtraction is enough.
    function automatic logic [2:0] res_step(input logic [2:0] r, input logic b);
        logic [3:0] v;
        v = {r, b};
        if (v >= 4'd5) begin
            v = v - 4'd5;
        end
        return v[2:0];
    endfunction

    // Check value that makes payload*8 + c divisible by 5.
    function automatic logic [2:0] check_of(input logic [2:0] r);
        logic [2:0] c;
        case (r)
            3'd0:    c = 3'd0;
            3'd1:    c = 3'd2;
            3'd2:    c = 3'd4;
            3'd3:    c = 3'd1;
            3'd4:    c = 3'd3;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            res_q   <= 3'd0;
            cnt_q   <= 5'd0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            chk_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            chk_q   <= chk_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sout_d  = 1'b0;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        chk_d   = chk_q;
        chk_new = check_of(res_q);

        case (state_q)
            IDLE: begin
                // din_ready is 1 here, so din_valid alone completes the
                // handshake. The MSB goes out at this same edge and the
                // residue restarts from 0 with that bit folded in.
                if (bus.din_valid) begin
                    state_d = DATA;
                    shreg_d = {bus.din[DATA_W-2:0], 1'b0};
                    res_d   = res_step(3'd0, bus.din[DATA_W-1]);
                    cnt_d   = 5'd0;
                    sout_d  = bus.din[DATA_W-1];
                    vld_d   = 1'b1;
                    fs_d    = 1'b1;
                end
            end

            DATA: begin
                vld_d = 1'b1;
                if (cnt_q != LAST_DATA) begin
                    sout_d  = shreg_q[DATA_W-1];
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    res_d   = res_step(res_q, shreg_q[DATA_W-1]);
                    cnt_d   = cnt_q + 5'd1;
                end else begin
                    // res_q now covers the whole payload; chk is updated
                    // so it is visible from the first check bit onwards.
                    state_d = CHECK;
                    chk_d   = chk_new;
                    sout_d  = chk_new[2];
                    cnt_d   = 5'd0;
                end
            end

            CHECK: begin
                case (cnt_q)
                    5'd0: begin
                        sout_d = chk_q[1];
                        vld_d  = 1'b1;
                        cnt_d  = 5'd1;
                    end
                    5'd1: begin
                        sout_d = chk_q[0];
                        vld_d  = 1'b1;
                        fe_d   = 1'b1;
                        cnt_d  = 5'd2;
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = 5'd0;
                    end
                endcase
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.din_ready   = (state_q == IDLE);
    assign bus.sout        = sout_q;
    assign bus.sout_valid  = vld_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;
    assign bus.chk         = chk_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mod5_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_mod5_frame_tx
//   Bench for mod5_frame_tx (DATA_W=8). A frame-level model turns every
//   accepted payload into its list of output beats; a compare process checks
//   the DUT against the model every cycle. A frame collector rebuilds frame
//   values from sout and runs a serial divisible-by-5 check on each frame.
// -----------------------------------------------------------------------------
module tb_mod5_frame_tx;

    localparam int DATA_W = 8;
    localparam int FLEN   = DATA_W + 3;
    localparam int BEAT_W = 8;   // {valid, sout, start, end, upd, chk[2:0]}

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    mod5_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    mod5_frame_tx #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: an accepted payload becomes FLEN beats plus one
    // idle beat; the transmitter is ready exactly when no beats remain.
    // ------------------------------------------------------------------
    logic [BEAT_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] cur_beat  = '0;
    logic              exp_ready = 1'b1;
    logic [2:0]        exp_chk   = 3'd0;

    function automatic logic [2:0] model_chk(input int d);
        return 3'((2 * (d % 5)) % 5);
    endfunction

    task automatic push_frame(input int d);
        int          c;
        logic [10:0] val;
        logic [BEAT_W-1:0] b;
        c   = model_chk(d);
        val = 11'(d * 8 + c);
        for (int i = 0; i < FLEN; i++) begin
            b    = '0;
            b[7] = 1'b1;
            b[6] = val[FLEN-1-i];
            b[5] = (i == 0);
            b[4] = (i == FLEN - 1);
            b[3] = (i == DATA_W);
            b[2:0] = 3'(c);
            exp_q.push_back(b);
        end
        exp_q.push_back('0);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            cur_beat  = '0;
            exp_ready = 1'b1;
            exp_chk   = 3'd0;
        end else begin
            if (exp_q.size() == 0 && bus.din_valid === 1'b1)
                push_frame(int'(bus.din));
            if (exp_q.size() > 0) cur_beat = exp_q.pop_front();
            else                  cur_beat = '0;
            if (cur_beat[3]) exp_chk = cur_beat[2:0];
            exp_ready = (exp_q.size() == 0);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check_val("din_ready",   int'(bus.din_ready),   int'(exp_ready));
        check_val("sout_valid",  int'(bus.sout_valid),  int'(cur_beat[7]));
        check_val("sout",        int'(bus.sout),        int'(cur_beat[6]));
        check_val("frame_start", int'(bus.frame_start), int'(cur_beat[5]));
        check_val("frame_end",   int'(bus.frame_end),   int'(cur_beat[4]));
        check_val("chk",         int'(bus.chk),         int'(exp_chk));
    end

    // ------------------------------------------------------------------
    // Frame collector + serial divisible-by-5 checker
    // ------------------------------------------------------------------
    int cap_val[$];
    int cap_chk[$];
    int acc   = 0;
    int res5  = 0;
    int nbits = 0;
    int n_start = 0;
    int n_end   = 0;

    always @(negedge clk) begin
        if (reset) begin
            acc = 0; res5 = 0; nbits = 0;
        end else if (bus.sout_valid === 1'b1) begin
            if (bus.frame_start === 1'b1) begin
                acc = 0; res5 = 0; nbits = 0;
                n_start++;
            end
            acc   = acc * 2 + int'(bus.sout);
            res5  = (2 * res5 + int'(bus.sout)) % 5;
            nbits++;
            if (bus.frame_end === 1'b1) begin
                n_end++;
                check_val("div5_residue", res5, 0);
                check_val("frame_bits", nbits, FLEN);
                cap_val.push_back(acc);
                cap_chk.push_back(int'(bus.chk));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (always entered 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [DATA_W-1:0] d, input bit hold);
        logic rdy;
        int   n;
        bus.din       = d;
        bus.din_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.din_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 64);
        if (!rdy) check_val("handshake_timeout", 0, 1);
        #1;
        if (!hold) bus.din_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        idle_cycles(3);
        reset = 1'b0;

        // Quiet period after reset: no frame activity allowed.
        idle_cycles(20);
        check_val("quiet_starts", n_start, 0);
        check_val("quiet_ends",   n_end,   0);

        // Single frame 0x37.
        send(8'h37, 1'b0);
        idle_cycles(14);

        // Back-to-back with din_valid held high.
        send(8'h01, 1'b1);
        send(8'h07, 1'b1);
        send(8'h03, 1'b0);
        idle_cycles(14);

        // 0xFF with din disturbed and a stray din_valid pulse mid-frame.
        send(8'hFF, 1'b0);
        idle_cycles(3);
        bus.din       = 8'h00;
        bus.din_valid = 1'b1;
        idle_cycles(1);
        bus.din_valid = 1'b0;
        idle_cycles(12);

        // Reset during DATA cycle 4 of 0xA5.
        send(8'hA5, 1'b0);
        idle_cycles(2);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("abort_sout_valid", int'(bus.sout_valid), 0);
        check_val("abort_din_ready",  int'(bus.din_ready),  1);
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(2);
        send(8'h02, 1'b0);
        idle_cycles(14);

        // Every payload, random gaps, random valid hold, junk din while idle.
        for (int d = 0; d < 256; d++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.din = DATA_W'($urandom);
                idle_cycles(1);
            end
            send(DATA_W'(d), 1'($urandom_range(0, 1)));
        end
        bus.din_valid = 1'b0;
        idle_cycles(20);

        // Hand-computed frame values and check values.
        check_val("frame_count", cap_val.size(), 262);
        if (cap_val.size() >= 6) begin
            check_val("f37_value", cap_val[0], 440);
            check_val("f37_chk",   cap_chk[0], 0);
            check_val("f01_value", cap_val[1], 10);
            check_val("f01_chk",   cap_chk[1], 2);
            check_val("f07_value", cap_val[2], 60);
            check_val("f07_chk",   cap_chk[2], 4);
            check_val("f03_value", cap_val[3], 25);
            check_val("f03_chk",   cap_chk[3], 1);
            check_val("fFF_value", cap_val[4], 2040);
            check_val("fFF_chk",   cap_chk[4], 0);
            check_val("f02_value", cap_val[5], 20);
            check_val("f02_chk",   cap_chk[5], 4);
        end
        if (cap_val.size() == 262) begin
            for (int d = 0; d < 256; d++)
                check_val("sweep_value", cap_val[6 + d], d * 8 + int'(model_chk(d)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
